// File: rtl/mux21_rr_arbiter_pkg.sv
// Shared definitions for the 2:1 round-robin mux arbiter: FSM state
// encodings, source identifiers and a small grant-decoding helper.
package mux21_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Maps a source identifier onto the grant state that serves it.
    function automatic state_t grantOf(input logic src);
        return (src == SRC_B) ? ST_GNT_B : ST_GNT_A;
    endfunction

endpackage

// File: rtl/mux21_out_reg.sv
// Output holding register for the arbiter: one beat (source tag + data)
// with a valid flag. A load always wins; the upstream FSM only loads when
// the register is empty or being drained in the same cycle.
module mux21_out_reg
    import mux21_rr_arbiter_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Load replaces the held beat; otherwise a consume empties the register and data stays put.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/mux21_rr_arbiter.sv
// Round-robin arbiter for two valid/ready sources sharing one registered
// output. A grant lasts up to MAX_BURST beats, or until the granted source
// goes idle, and then passes straight to the other source if it is waiting.
module mux21_rr_arbiter
    import mux21_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              busy
);

    localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_prio;
    logic              w_prioNext;
    logic [CNT_W-1:0]  r_beatCnt;
    logic [CNT_W-1:0]  w_beatCntNext;

    logic              w_outValid;
    logic              w_space;
    logic              w_xferA;
    logic              w_xferB;
    logic              w_load;
    logic [DATA_W:0]   w_loadBeat;
    logic [DATA_W:0]   w_outBeat;

    // The output register can take a beat when empty or when its beat leaves this cycle.
    assign w_space    = ~w_outValid | out_ready;
    assign a_ready    = (r_state == ST_GNT_A) & w_space;
    assign b_ready    = (r_state == ST_GNT_B) & w_space;
    assign w_xferA    = a_valid & a_ready;
    assign w_xferB    = b_valid & b_ready;
    assign w_load     = w_xferA | w_xferB;
    assign w_loadBeat = w_xferB ? {SRC_B, b_data} : {SRC_A, a_data};
    assign busy       = (r_state != ST_IDLE);

    // Arbitration, burst counting and hand-over; release goes directly to the other grant when it waits.
    always_comb begin
        w_stateNext   = r_state;
        w_prioNext    = r_prio;
        w_beatCntNext = r_beatCnt;
        case (r_state)
            ST_IDLE: begin
                if (a_valid && b_valid) begin
                    w_stateNext = grantOf(r_prio);
                end else if (a_valid) begin
                    w_stateNext = ST_GNT_A;
                end else if (b_valid) begin
                    w_stateNext = ST_GNT_B;
                end
            end
            ST_GNT_A: begin
                if (!a_valid || (w_xferA && (r_beatCnt == LAST_BEAT))) begin
                    w_prioNext    = SRC_B;
                    w_beatCntNext = '0;
                    w_stateNext   = b_valid ? ST_GNT_B : ST_IDLE;
                end else if (w_xferA) begin
                    w_beatCntNext = r_beatCnt + CNT_W'(1);
                end
            end
            ST_GNT_B: begin
                if (!b_valid || (w_xferB && (r_beatCnt == LAST_BEAT))) begin
                    w_prioNext    = SRC_A;
                    w_beatCntNext = '0;
                    w_stateNext   = a_valid ? ST_GNT_A : ST_IDLE;
                end else if (w_xferB) begin
                    w_beatCntNext = r_beatCnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext   = ST_IDLE;
                w_beatCntNext = '0;
            end
        endcase
    end

    // State, priority and burst counter registers; reset aborts any burst and hands the first tie to A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_prio    <= SRC_A;
            r_beatCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_prio    <= w_prioNext;
            r_beatCnt <= w_beatCntNext;
        end
    end

    mux21_out_reg #(
        .W (DATA_W + 1)
    ) u_outReg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_loadBeat),
        .i_ready (out_ready),
        .o_valid (w_outValid),
        .o_data  (w_outBeat)
    );

    assign out_valid = w_outValid;
    assign out_src   = w_outBeat[DATA_W];
    assign out_data  = w_outBeat[DATA_W-1:0];

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Self-checking bench for mux21_rr_arbiter: queued sources drive A and B,
// expected beats go into a scoreboard in the order arbitration must produce
// them, and every consumed output beat is popped and compared.
module tb_mux21_rr_arbiter;

    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;
    logic              busy;

    int          checkCount = 0;
    int          failCount  = 0;
    logic [8:0]  expQ[$];
    logic [7:0]  aQ[$];
    logic [7:0]  bQ[$];
    int          outCyc[$];
    int          tCycle     = 0;
    int          stallLo    = 1000;
    int          stallHi    = -1;
    bit          stallCheck = 1'b0;
    logic [8:0]  stallBeat  = 9'h000;
    int          busyLowCnt = 0;

    always #5 clk = ~clk;

    mux21_rr_arbiter #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Counts one comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", tag, observed, expected, tCycle);
        end
    endtask

    // Drives source and consumer pins from the source queues and the stall window.
    task automatic refreshInputs();
        a_valid   = (aQ.size() > 0);
        a_data    = (aQ.size() > 0) ? aQ[0] : 8'h00;
        b_valid   = (bQ.size() > 0);
        b_data    = (bQ.size() > 0) ? bQ[0] : 8'h00;
        out_ready = !((tCycle >= stallLo) && (tCycle <= stallHi));
    endtask

    // One clock cycle: observe at the falling edge, advance sources after the rising edge.
    task automatic applyStimulus();
        logic       aFire;
        logic       bFire;
        logic       oFire;
        logic [8:0] beat;
        @(negedge clk);
        aFire = a_valid & a_ready;
        bFire = b_valid & b_ready;
        oFire = out_valid & out_ready;
        if (!busy && (tCycle >= 1) && (expQ.size() > 1)) busyLowCnt++;
        if (stallCheck && (tCycle >= stallLo) && (tCycle <= stallHi)) begin
            checkOutput("stall_a_ready", {31'd0, a_ready}, 32'd0);
            checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_hold_beat", {23'd0, out_src, out_data}, {23'd0, stallBeat});
        end
        if (oFire) begin
            beat = {out_src, out_data};
            outCyc.push_back(tCycle);
            if (expQ.size() == 0) checkOutput("extra_beat", {23'd0, beat}, 32'hFFFF_FFFF);
            else                  checkOutput("beat", {23'd0, beat}, {23'd0, expQ.pop_front()});
        end
        @(posedge clk);
        #1;
        if (aFire && (aQ.size() > 0)) void'(aQ.pop_front());
        if (bFire && (bQ.size() > 0)) void'(bQ.pop_front());
        tCycle++;
        refreshInputs();
    endtask

    task automatic startTest();
        tCycle     = 0;
        busyLowCnt = 0;
        outCyc.delete();
        refreshInputs();
    endtask

    task automatic runUntilDrained(input string tag, input int budget);
        int n = 0;
        while (((expQ.size() > 0) || (aQ.size() > 0) || (bQ.size() > 0)) && (n < budget)) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drained"}, expQ.size() + aQ.size() + bQ.size(), 32'd0);
        expQ.delete();
        aQ.delete();
        bQ.delete();
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        aQ.delete();
        bQ.delete();
        expQ.delete();
        tCycle = 0;
        refreshInputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset with both sources requesting: nothing may be granted.
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        a_data    = 8'hAA;
        b_valid   = 1'b1;
        b_data    = 8'hBB;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_a_ready", {31'd0, a_ready}, 32'd0);
        checkOutput("rst_b_ready", {31'd0, b_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_out_beat", {23'd0, out_src, out_data}, 32'd0);
        applyReset();

        // Single source A: three beats, first output two cycles after valid.
        aQ = '{8'h11, 8'h22, 8'h33};
        expQ = '{9'h011, 9'h022, 9'h033};
        startTest();
        runUntilDrained("t2", 100);
        if (outCyc.size() > 0) checkOutput("t2_first_latency", outCyc[0], 32'd2);
        @(negedge clk);
        checkOutput("t2_idle_after_release", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        tCycle++;

        // Tie with both sources streaming: bursts of four alternate, no bubbles.
        applyReset();
        for (int n = 0; n < 8; n++) begin
            aQ.push_back(8'hA0 + 8'(n));
            bQ.push_back(8'hB0 + 8'(n));
        end
        for (int n = 0; n < 4; n++) expQ.push_back({1'b0, 8'hA0 + 8'(n)});
        for (int n = 0; n < 4; n++) expQ.push_back({1'b1, 8'hB0 + 8'(n)});
        for (int n = 4; n < 8; n++) expQ.push_back({1'b0, 8'hA0 + 8'(n)});
        for (int n = 4; n < 8; n++) expQ.push_back({1'b1, 8'hB0 + 8'(n)});
        startTest();
        runUntilDrained("t3", 100);
        checkOutput("t3_beat_count", outCyc.size(), 32'd16);
        if (outCyc.size() == 16) checkOutput("t3_no_bubble_span", outCyc[15] - outCyc[0], 32'd15);
        checkOutput("t3_busy_gaps", busyLowCnt, 32'd0);

        // Backpressure mid-burst: second beat held for five cycles, nothing lost or repeated.
        applyReset();
        for (int n = 0; n < 8; n++) begin
            aQ.push_back(8'h40 + 8'(n));
            expQ.push_back({1'b0, 8'h40 + 8'(n)});
        end
        stallLo    = 3;
        stallHi    = 7;
        stallBeat  = 9'h041;
        stallCheck = 1'b1;
        startTest();
        runUntilDrained("t4", 100);
        stallCheck = 1'b0;
        stallLo    = 1000;
        stallHi    = -1;
        refreshInputs();

        // Early release: A stops after two beats, B takes over without an idle cycle.
        applyReset();
        aQ   = '{8'hC0, 8'hC1};
        bQ   = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        expQ = '{9'h0C0, 9'h0C1, 9'h1D0, 9'h1D1, 9'h1D2, 9'h1D3};
        startTest();
        runUntilDrained("t5", 100);
        if (outCyc.size() >= 3) checkOutput("t5_b_first_cycle", outCyc[2], 32'd5);
        checkOutput("t5_busy_gaps", busyLowCnt, 32'd0);
        aQ   = '{8'hE0, 8'hE1};
        bQ   = '{8'hF0};
        expQ = '{9'h0E0, 9'h0E1, 9'h1F0};
        startTest();
        runUntilDrained("t5_tie", 100);

        // Reset mid-burst: prio is B beforehand, reset must restore A and drop the held beat.
        applyReset();
        aQ   = '{8'h50, 8'h51, 8'h52};
        expQ = '{9'h050, 9'h051, 9'h052};
        startTest();
        runUntilDrained("t6_pre", 100);
        applyStimulus();
        aQ   = '{8'h80, 8'h81, 8'h82, 8'h83};
        expQ = '{9'h080, 9'h081};
        startTest();
        repeat (3) applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        aQ.delete();
        bQ.delete();
        refreshInputs();
        @(negedge clk);
        checkOutput("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_rst_a_ready", {31'd0, a_ready}, 32'd0);
        checkOutput("t6_rst_pending", expQ.size(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        aQ   = '{8'h90};
        bQ   = '{8'h91};
        expQ = '{9'h090, 9'h191};
        startTest();
        runUntilDrained("t6_tie", 100);
        repeat (3) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
